// File: rtl/boid_render_scheduler.sv
// rtl/boid_render_scheduler.sv - frame render scheduler that scans boid positions into display RAM writes
//
// Purpose: on a refresh request, clears/swaps the display RAM, walks boid_sel over
// the active boids and emits one display write (data constant 1) per boid at
// address x + 640*y, one cycle after the boid is selected.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   refresh_req       frame render request, sampled every cycle
//   num_boids         active boid count, latched (clamped to MAX_BOIDS) at render start
//   boid_x, boid_y    position of the boid addressed by boid_sel (combinational)
//   boid_sel          index of the boid being read, 0 outside the scan
//   ram_switch        one-cycle pulse at render start that clears/swaps the display RAM
//   disp_we/addr      display RAM write strobe and address
//   busy, done        render in progress / one-cycle end-of-render pulse
//   overrun_cnt       saturating count of requests that arrived while busy
//
// Configuration: define BOID_CLIP_EN to suppress writes for boids outside 640x480.

module boid_render_scheduler #(
  parameter int MAX_BOIDS  = 128,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         refresh_req,
  input  logic [$clog2(MAX_BOIDS):0]   num_boids,
  input  logic [9:0]                   boid_x,
  input  logic [8:0]                   boid_y,
  output logic [$clog2(MAX_BOIDS)-1:0] boid_sel,
  output logic                         ram_switch,
  output logic                         disp_we,
  output logic [ADDR_WIDTH-1:0]        disp_addr,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   overrun_cnt
);

  localparam int SW = $clog2(MAX_BOIDS);
  localparam int NW = SW + 1;
  // 20 bits hold the largest possible x + 640*y; widen further only if the bus is wider.
  localparam int FW = (ADDR_WIDTH > 20) ? ADDR_WIDTH : 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [NW-1:0]       n_q;
  logic [SW-1:0]       sel_q;
  logic                pending_q;
  logic                ram_switch_q;
  logic                disp_we_q;
  logic [ADDR_WIDTH-1:0] disp_addr_q;
  logic                busy_q;
  logic                done_q;
  logic [7:0]          overrun_q;

  logic [FW-1:0]       addr_full;
  logic                in_range;
  logic [NW-1:0]       n_clamped;
  logic                scan_last;
  logic [7:0]          overrun_d;

  // 640*y as shift-add, kept at full precision before truncation to the bus width.
  assign addr_full = (FW'(boid_y) << 9) + (FW'(boid_y) << 7) + FW'(boid_x);

`ifdef BOID_CLIP_EN
  assign in_range = (boid_x < 10'd640) && (boid_y < 9'd480);
`else
  assign in_range = 1'b1;
`endif

  assign n_clamped = (num_boids > NW'(MAX_BOIDS)) ? NW'(MAX_BOIDS) : num_boids;
  assign scan_last = ((NW'(sel_q) + NW'(1)) == n_q);
  assign overrun_d = (overrun_q == 8'hFF) ? overrun_q : overrun_q + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      sel_q        <= '0;
      pending_q    <= 1'b0;
      ram_switch_q <= 1'b0;
      disp_we_q    <= 1'b0;
      disp_addr_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= '0;
    end else begin
      ram_switch_q <= 1'b0;
      done_q       <= 1'b0;
      disp_we_q    <= 1'b0;

      // Write pipeline: the boid selected in a SCAN cycle is written in the next cycle,
      // so the last boid's write lands in DRAIN.
      if (state_q == ST_SCAN) begin
        disp_we_q   <= in_range;
        disp_addr_q <= addr_full[ADDR_WIDTH-1:0];
      end

      // Requests while busy (DONE included) collapse into one pending render.
      if (state_q != ST_IDLE && refresh_req) begin
        pending_q <= 1'b1;
        overrun_q <= overrun_d;
      end

      case (state_q)
        ST_IDLE: begin
          if (refresh_req || pending_q) begin
            n_q          <= n_clamped;
            pending_q    <= 1'b0;
            state_q      <= ST_CLEAR;
            ram_switch_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (n_q != '0) begin
            state_q <= ST_SCAN;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_last) begin
            state_q <= ST_DRAIN;
            sel_q   <= '0;
          end else begin
            sel_q <= sel_q + SW'(1);
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign boid_sel    = sel_q;
  assign ram_switch  = ram_switch_q;
  assign disp_we     = disp_we_q;
  assign disp_addr   = disp_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_boid_render_scheduler.sv
// tb/tb_boid_render_scheduler.sv - self-checking bench for boid_render_scheduler

module tb_boid_render_scheduler;

  localparam int MAXB = 128;
  localparam int AW   = 20;

`ifdef BOID_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          refresh_req;
  logic [7:0]    num_boids;
  logic [9:0]    boid_x;
  logic [8:0]    boid_y;
  logic [6:0]    boid_sel;
  logic          ram_switch;
  logic          disp_we;
  logic [AW-1:0] disp_addr;
  logic          busy;
  logic          done;
  logic [7:0]    overrun_cnt;

  logic [9:0] bx [MAXB];
  logic [8:0] by [MAXB];

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    int x;
    int y;
    int addr;
    bit we;
  } vec_t;

  vec_t vecs [9];

  always #5 clock = ~clock;

  always_comb begin
    boid_x = bx[boid_sel];
    boid_y = by[boid_sel];
  end

  boid_render_scheduler #(.MAX_BOIDS(MAXB), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .refresh_req (refresh_req),
    .num_boids   (num_boids),
    .boid_x      (boid_x),
    .boid_y      (boid_y),
    .boid_sel    (boid_sel),
    .ram_switch  (ram_switch),
    .disp_we     (disp_we),
    .disp_addr   (disp_addr),
    .busy        (busy),
    .done        (done),
    .overrun_cnt (overrun_cnt)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start(input int n, input int n_after);
    num_boids   = 8'(n);
    refresh_req = 1'b1;
    @(negedge clock);
    refresh_req = 1'b0;
    num_boids   = 8'(n_after);
  endtask

  // Entered at the CLEAR-cycle negedge; returns at the negedge of the following IDLE cycle.
  task automatic observe(input string tag, input int exp_len, input int inject);
    int cyc;
    cyc = 1;
    check($sformatf("%s_clear_ram_switch", tag), ram_switch, 1);
    check($sformatf("%s_clear_busy", tag), busy, 1);
    check($sformatf("%s_clear_we", tag), disp_we, 0);
    refresh_req = (inject >= 1);
    while (!done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      refresh_req = ((cyc % 2) == 1) && (cyc <= 2 * inject - 1);
      if (ram_switch) check($sformatf("%s_extra_ram_switch", tag), ram_switch, 0);
      if (disp_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_unexpected_write actual=%0d required=none", tag, disp_addr);
        end else begin
          check($sformatf("%s_addr", tag), disp_addr, exp_q.pop_front());
        end
      end
    end
    refresh_req = 1'b0;
    check($sformatf("%s_len", tag), cyc, exp_len);
    check($sformatf("%s_missing_writes", tag), exp_q.size(), 0);
    check($sformatf("%s_done_we", tag), disp_we, 0);
    @(negedge clock);
    check($sformatf("%s_done_pulse", tag), done, 0);
    check($sformatf("%s_idle_busy", tag), busy, 0);
    check($sformatf("%s_idle_sel", tag), boid_sel, 0);
    check($sformatf("%s_idle_we", tag), disp_we, 0);
  endtask

  initial begin
    int k;
    vecs[0] = '{x: 1,    y: 0,   addr: 1,      we: 1'b1};
    vecs[1] = '{x: 639,  y: 479, addr: 307199, we: 1'b1};
    vecs[2] = '{x: 10,   y: 2,   addr: 1290,   we: 1'b1};
    vecs[3] = '{x: 700,  y: 5,   addr: 3900,   we: !CLIP};
    vecs[4] = '{x: 0,    y: 1,   addr: 640,    we: 1'b1};
    vecs[5] = '{x: 5,    y: 100, addr: 64005,  we: 1'b1};
    vecs[6] = '{x: 1023, y: 511, addr: 328063, we: !CLIP};
    vecs[7] = '{x: 639,  y: 0,   addr: 639,    we: 1'b1};
    vecs[8] = '{x: 0,    y: 479, addr: 306560, we: 1'b1};

    for (int i = 0; i < MAXB; i++) begin
      bx[i] = '0;
      by[i] = '0;
    end
    reset       = 1'b1;
    refresh_req = 1'b0;
    num_boids   = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", disp_we, 0);
    check("rst_ram_switch", ram_switch, 0);
    check("rst_sel", boid_sel, 0);
    check("rst_addr", disp_addr, 0);
    check("rst_overrun", overrun_cnt, 0);

    // Reset wins over a simultaneous request.
    refresh_req = 1'b1;
    num_boids   = 8'd3;
    @(negedge clock);
    reset       = 1'b0;
    refresh_req = 1'b0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_ram_switch", ram_switch, 0);
    @(negedge clock);
    check("rst_prio_idle_busy", busy, 0);

    // Single-boid renders from the vector table; num_boids changes mid-render.
    for (int i = 0; i < 9; i++) begin
      bx[0] = 10'(vecs[i].x);
      by[0] = 9'(vecs[i].y);
      if (vecs[i].we) exp_q.push_back(vecs[i].addr);
      start(1, 77);
      observe($sformatf("vec%0d", i), 4, 0);
    end

    // Three boids, six-cycle render.
    for (int i = 0; i < 3; i++) begin
      bx[i] = 10'(vecs[i].x);
      by[i] = 9'(vecs[i].y);
      exp_q.push_back(vecs[i].addr);
    end
    start(3, 0);
    observe("n3", 6, 0);

    // Empty render.
    start(0, 5);
    observe("n0", 2, 0);

    // Count clamped to MAX_BOIDS; address order proves boid_sel runs 0..127.
    for (int i = 0; i < MAXB; i++) begin
      bx[i] = 10'(i);
      by[i] = '0;
      exp_q.push_back(i);
    end
    start(200, 3);
    observe("clamp", 131, 0);

    // Out-of-range boid first.
    bx[0] = 10'(vecs[3].x);
    by[0] = 9'(vecs[3].y);
    bx[1] = 10'(vecs[4].x);
    by[1] = 9'(vecs[4].y);
    if (vecs[3].we) exp_q.push_back(vecs[3].addr);
    exp_q.push_back(vecs[4].addr);
    start(2, 2);
    observe("clip", 5, 0);
    check("pre_overrun", overrun_cnt, 0);

    // Three requests while busy collapse into one follow-up render.
    for (int i = 0; i < 3; i++) begin
      bx[i] = 10'(vecs[i].x);
      by[i] = 9'(vecs[i].y);
      exp_q.push_back(vecs[i].addr);
    end
    start(3, 3);
    observe("ovr_a", 6, 3);
    check("ovr_cnt", overrun_cnt, 3);
    @(negedge clock);
    for (int i = 0; i < 3; i++) exp_q.push_back(vecs[i].addr);
    observe("ovr_b", 6, 0);
    check("ovr_cnt_after", overrun_cnt, 3);
    @(negedge clock);
    check("ovr_no_third", ram_switch, 0);
    check("ovr_no_third_busy", busy, 0);

    // Reset mid-scan discards the in-flight write and the overrun count.
    for (int i = 0; i < 10; i++) begin
      bx[i] = 10'(i);
      by[i] = '0;
    end
    start(10, 10);
    k = 0;
    while (boid_sel != 7'd5 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("mid_sel_reached", boid_sel, 5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", disp_we, 0);
    check("mid_rst_overrun", overrun_cnt, 0);
    check("mid_rst_sel", boid_sel, 0);
    check("mid_rst_addr", disp_addr, 0);
    @(negedge clock);
    check("mid_rst_we2", disp_we, 0);
    check("mid_rst_busy2", busy, 0);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    start(2, 2);
    observe("restart", 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boid_render_scheduler.md
BOID_RENDER_SCHEDULER -- requirements
Module: boid_render_scheduler

Interface
REQ-001 SHALL have parameter MAX_BOIDS, default 128, the number of boid processing units that can be scanned.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, the display-memory address width in bits.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port refresh_req, input, 1 bit: request to start a frame render, sampled every cycle.
REQ-006 SHALL have port num_boids, input, clog2(MAX_BOIDS)+1 bits: active boid count, latched at render start.
REQ-007 SHALL have port boid_x, input, 10 bits: x position of the currently selected boid, combinational from boid_sel.
REQ-008 SHALL have port boid_y, input, 9 bits: y position of the currently selected boid, combinational from boid_sel.
REQ-009 SHALL have port boid_sel, output, clog2(MAX_BOIDS) bits: index of the boid being read.
REQ-010 SHALL have port ram_switch, output, 1 bit: one-cycle pulse that clears or swaps the display RAM.
REQ-011 SHALL have port disp_we, output, 1 bit: display RAM write enable (write data is constant 1).
REQ-012 SHALL have port disp_addr, output, ADDR_WIDTH bits: display RAM write address.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a render.
REQ-015 SHALL have port overrun_cnt, output, 8 bits: count of refresh requests that arrived while busy.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, SCAN, DRAIN and DONE.
REQ-017 IDLE: on refresh_req=1 or pending=1, SHALL latch N = min(num_boids, MAX_BOIDS), clear pending and go to CLEAR.
REQ-018 CLEAR: SHALL assert ram_switch for exactly this one cycle, then go to SCAN if N>0, else go to DONE.
REQ-019 SCAN: boid_sel SHALL take the values 0,1,...,N-1 on consecutive cycles; after N-1 the FSM SHALL go to DRAIN.
REQ-020 Write pipeline: boid_x/boid_y sampled in the cycle boid_sel=k SHALL produce disp_we=1 and disp_addr = x + 640*y in the next cycle (latency 1).
REQ-021 The address arithmetic SHALL be (y<<9)+(y<<7)+x, computed at full precision and truncated to ADDR_WIDTH.
REQ-022 DRAIN: SHALL last one cycle, carry the final pipelined write, then go to DONE.
REQ-023 DONE: SHALL assert done for one cycle, then return to IDLE.
REQ-024 Total render length from CLEAR to DONE inclusive SHALL be N+3 cycles for N>0, and 2 cycles for N=0.
REQ-025 disp_we SHALL be 0 in IDLE, CLEAR and DONE, and no write SHALL occur while ram_switch=1.
REQ-026 boid_sel SHALL hold 0 outside SCAN.
REQ-027 A refresh_req while busy=1 SHALL set pending, which starts the next render on the first IDLE cycle.
REQ-028 A refresh_req while busy=1 SHALL also increment overrun_cnt, which saturates at 255.
REQ-029 Multiple requests while busy SHALL collapse into one pending render.
REQ-030 A change of num_boids during a render SHALL NOT affect that render.
REQ-031 A refresh_req in the DONE cycle SHALL count as busy, set pending and increment overrun_cnt.

Reset
REQ-032 On reset=1 at any clock edge, including mid-render, the FSM SHALL go to IDLE.
REQ-033 On reset, pending, boid_sel, ram_switch, disp_we, done and busy SHALL become 0.
REQ-034 On reset, disp_addr and overrun_cnt SHALL become 0.
REQ-035 An in-flight pipelined write SHALL be discarded on reset.
REQ-036 reset SHALL take priority over refresh_req in the same cycle.

Configuration
REQ-037 With BOID_CLIP_EN defined, a pipelined write whose sampled x>=640 or y>=480 SHALL be suppressed (disp_we=0); FSM timing SHALL be unchanged.
REQ-038 Without BOID_CLIP_EN, every scanned boid SHALL produce a write with the truncated address of REQ-021.

Verification
REQ-039 Reset, then refresh_req pulse with num_boids=3 and boids (1,0),(639,479),(10,2): ram_switch seen 1 cycle; then writes to addresses 1, 307199 and 1290 on consecutive cycles; done pulse; 6 cycles from CLEAR to DONE.
REQ-040 num_boids=0: ram_switch then done on the next cycle, no disp_we.
REQ-041 num_boids=200 with MAX_BOIDS=128: exactly 128 writes, boid_sel wraps never, sequence 0..127.
REQ-042 Three refresh_req pulses during one render: overrun_cnt=3, exactly one further render starts on the cycle after returning to IDLE.
REQ-043 With BOID_CLIP_EN, boid at (700,5) among N=2: only the in-range boid is written. Without BOID_CLIP_EN: both are written, the first at address 3900.
REQ-044 Assert reset during SCAN at boid_sel=5: next cycle busy=0 and disp_we=0; overrun_cnt=0; the next refresh_req restarts from boid_sel 0.
